// File: rtl/dmi_access_arbiter.sv
// Two-requester round-robin arbiter in front of a single RISC-V DMI port.
// One transaction in flight; requests are issued, awaited with a timeout, and answered to the owner.
module dmi_access_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        a_req_valid,
  output logic        a_req_ready,
  input  logic [6:0]  a_req_addr,
  input  logic [31:0] a_req_data,
  input  logic [1:0]  a_req_op,
  output logic        a_resp_valid,
  input  logic        a_resp_ready,
  output logic [31:0] a_resp_data,
  output logic [1:0]  a_resp_resp,
  input  logic        b_req_valid,
  output logic        b_req_ready,
  input  logic [6:0]  b_req_addr,
  input  logic [31:0] b_req_data,
  input  logic [1:0]  b_req_op,
  output logic        b_resp_valid,
  input  logic        b_resp_ready,
  output logic [31:0] b_resp_data,
  output logic [1:0]  b_resp_resp,
  output logic        dmi_req_valid,
  input  logic        dmi_req_ready,
  output logic [6:0]  dmi_req_addr,
  output logic [31:0] dmi_req_data,
  output logic [1:0]  dmi_req_op,
  input  logic        dmi_resp_valid,
  output logic        dmi_resp_ready,
  input  logic [31:0] dmi_resp_data,
  input  logic [1:0]  dmi_resp_resp,
  output logic        busy,
  output logic        owner,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a valid side holds its fields stable until that edge, and ready never waits on nothing.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RESP_FAILED  = 2'd2;
  localparam logic [1:0] OP_RESERVED  = 2'd3;

  state_t      state, next_state;
  logic [7:0]  cnt;
  logic        last_b;
  logic        owner_q;
  logic [6:0]  lat_addr;
  logic [31:0] lat_data;
  logic [1:0]  lat_op;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;

  logic        pick_b;
  logic        load_req, load_err, load_dmi, clr_cnt, inc_cnt, done;
  logic [1:0]  sel_op;

  // Round-robin pick: with both asking, prefer whoever was not served last.
  assign pick_b = b_req_valid & (~a_req_valid | ~last_b);
  assign sel_op = pick_b ? b_req_op : a_req_op;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state     = state;
    load_req       = 1'b0;
    load_err       = 1'b0;
    load_dmi       = 1'b0;
    clr_cnt        = 1'b0;
    inc_cnt        = 1'b0;
    done           = 1'b0;
    a_req_ready    = 1'b0;
    b_req_ready    = 1'b0;
    dmi_req_valid  = 1'b0;
    dmi_resp_ready = 1'b0;
    a_resp_valid   = 1'b0;
    b_resp_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        // Reset_n gating keeps every ready low while reset is held.
        dmi_resp_ready = reset_n;
        a_req_ready    = reset_n & a_req_valid & ~pick_b;
        b_req_ready    = reset_n & pick_b;
        if (reset_n & (a_req_valid | b_req_valid)) begin
          load_req = 1'b1;
          if (sel_op == OP_RESERVED) begin
            load_err   = 1'b1;
            next_state = S_RETURN;
          end else begin
            next_state = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        dmi_req_valid = 1'b1;
        if (dmi_req_ready) begin
          clr_cnt    = 1'b1;
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        dmi_resp_ready = 1'b1;
        inc_cnt        = 1'b1;
        if (dmi_resp_valid) begin
          load_dmi   = 1'b1;
          next_state = S_RETURN;
        end else if (cnt == TIMEOUT_LAST) begin
          load_err   = 1'b1;
          next_state = S_RETURN;
        end
      end
      S_RETURN: begin
        a_resp_valid = ~owner_q;
        b_resp_valid = owner_q;
        if (owner_q ? b_resp_ready : a_resp_ready) begin
          done       = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= 8'd0;
      last_b   <= 1'b1;
      owner_q  <= 1'b0;
      lat_addr <= 7'd0;
      lat_data <= 32'd0;
      lat_op   <= 2'd0;
      rsp_data <= 32'd0;
      rsp_resp <= 2'd0;
    end else begin
      if (load_req) begin
        owner_q  <= pick_b;
        lat_addr <= pick_b ? b_req_addr : a_req_addr;
        lat_data <= pick_b ? b_req_data : a_req_data;
        lat_op   <= sel_op;
      end
      if (load_err) begin
        rsp_data <= 32'd0;
        rsp_resp <= RESP_FAILED;
      end else if (load_dmi) begin
        rsp_data <= dmi_resp_data;
        rsp_resp <= dmi_resp_resp;
      end
      if (clr_cnt)      cnt <= 8'd0;
      else if (inc_cnt) cnt <= cnt + 8'd1;
      if (done) last_b <= owner_q;
    end
  end

  assign dmi_req_addr = lat_addr;
  assign dmi_req_data = lat_data;
  assign dmi_req_op   = lat_op;
  assign a_resp_data  = rsp_data;
  assign a_resp_resp  = rsp_resp;
  assign b_resp_data  = rsp_data;
  assign b_resp_resp  = rsp_resp;
  assign busy         = (state != S_IDLE);
  assign owner        = busy & owner_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_dmi_access_arbiter.sv
// Bench for dmi_access_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model (request queues, a simple DM responder, expected-response queues).
module tb_dmi_access_arbiter;

  localparam int T = 8;

  logic        clock, reset_n;
  logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
  logic [6:0]  a_req_addr;
  logic [31:0] a_req_data, a_resp_data;
  logic [1:0]  a_req_op, a_resp_resp;
  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
  logic [6:0]  b_req_addr;
  logic [31:0] b_req_data, b_resp_data;
  logic [1:0]  b_req_op, b_resp_resp;
  logic        dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_ready;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data, dmi_resp_data;
  logic [1:0]  dmi_req_op, dmi_resp_resp;
  logic        busy, owner;
  logic [1:0]  dbg_state;

  dmi_access_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr),
    .a_req_data(a_req_data), .a_req_op(a_req_op), .a_resp_valid(a_resp_valid),
    .a_resp_ready(a_resp_ready), .a_resp_data(a_resp_data), .a_resp_resp(a_resp_resp),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr),
    .b_req_data(b_req_data), .b_req_op(b_req_op), .b_resp_valid(b_resp_valid),
    .b_resp_ready(b_resp_ready), .b_resp_data(b_resp_data), .b_resp_resp(b_resp_resp),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready), .dmi_req_addr(dmi_req_addr),
    .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op), .dmi_resp_valid(dmi_resp_valid),
    .dmi_resp_ready(dmi_resp_ready), .dmi_resp_data(dmi_resp_data), .dmi_resp_resp(dmi_resp_resp),
    .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [40:0] req_a_q[$], req_b_q[$];   // {op, data, addr} waiting to be presented
  logic [40:0] fwd_q[$];                 // request expected on the DMI port
  logic [33:0] exp_a_q[$], exp_b_q[$];   // {resp, data} expected per requester
  bit          grant_log[$];             // 0 = A, 1 = B, in acceptance order

  // transaction phases of the reference model
  bit open_m, own_m, last_m, fwd_m, wait_m, ans_m;
  int k_m;

  // DM responder
  bit          dm_busy;
  int          dm_k, dm_d;
  logic [33:0] dm_rsp;
  int          dm_delay;                 // -1: random 0..T (T means late)
  bit          dm_rand;
  logic [33:0] dm_fix;

  int unsigned a_rdy_pct, b_rdy_pct, dmi_rdy_pct;
  int          n_resp_a, n_resp_b, n_dmi;
  logic [33:0] last_a, last_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_clear();
    open_m = 0; own_m = 0; last_m = 1; fwd_m = 0; wait_m = 0; ans_m = 0; k_m = 0;
    dm_busy = 0; dm_k = 0; dm_d = 0;
    req_a_q.delete(); req_b_q.delete(); fwd_q.delete();
    exp_a_q.delete(); exp_b_q.delete(); grant_log.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({a_req_ready, b_req_ready, a_resp_valid, b_resp_valid,
                             dmi_req_valid, dmi_resp_ready, busy, owner}), 64'd0);
    check({tag, "_dmi"}, 64'({dmi_req_op, dmi_req_data, dmi_req_addr}), 64'd0);
    check({tag, "_a"}, 64'({a_resp_resp, a_resp_data}), 64'd0);
    check({tag, "_b"}, 64'({b_resp_resp, b_resp_data}), 64'd0);
  endtask

  function automatic logic [40:0] rand_req(input logic [1:0] op);
    return {op, 32'($urandom()), 7'($urandom_range(127))};
  endfunction

  // ---------------- driver + model, one clock per call ----------------
  task automatic cycle();
    logic [40:0] ra, rb, r;
    bit pb, ga, gb, drr, a_hs, b_hs;
    @(negedge clock);
    ra = (req_a_q.size() > 0) ? req_a_q[0] : rand_req(2'($urandom_range(3)));
    rb = (req_b_q.size() > 0) ? req_b_q[0] : rand_req(2'($urandom_range(3)));
    a_req_valid = (req_a_q.size() > 0);
    b_req_valid = (req_b_q.size() > 0);
    {a_req_op, a_req_data, a_req_addr} = ra;
    {b_req_op, b_req_data, b_req_addr} = rb;
    a_resp_ready   = ($urandom_range(99) < a_rdy_pct);
    b_resp_ready   = ($urandom_range(99) < b_rdy_pct);
    dmi_req_ready  = !dm_busy && ($urandom_range(99) < dmi_rdy_pct);
    dmi_resp_valid = dm_busy && (dm_k >= dm_d);
    {dmi_resp_resp, dmi_resp_data} = dmi_resp_valid ? dm_rsp : {2'($urandom_range(3)), 32'($urandom())};
    #1;
    pb  = b_req_valid && (!a_req_valid || !last_m);
    ga  = !open_m && a_req_valid && !pb;
    gb  = !open_m && pb;
    drr = !open_m || wait_m;
    check("a_req_ready", 64'(a_req_ready), 64'(ga));
    check("b_req_ready", 64'(b_req_ready), 64'(gb));
    check("busy", 64'(busy), 64'(open_m));
    check("owner", 64'(owner), 64'(open_m && own_m));
    check("dmi_req_valid", 64'(dmi_req_valid), 64'(fwd_m));
    if (fwd_m) check("dmi_req_fields", 64'({dmi_req_op, dmi_req_data, dmi_req_addr}), 64'(fwd_q[0]));
    check("dmi_resp_ready", 64'(dmi_resp_ready), 64'(drr));
    check("a_resp_valid", 64'(a_resp_valid), 64'(ans_m && !own_m));
    check("b_resp_valid", 64'(b_resp_valid), 64'(ans_m && own_m));
    if (ans_m && !own_m && exp_a_q.size() > 0)
      check("a_resp_fields", 64'({a_resp_resp, a_resp_data}), 64'(exp_a_q[0]));
    if (ans_m && own_m && exp_b_q.size() > 0)
      check("b_resp_fields", 64'({b_resp_resp, b_resp_data}), 64'(exp_b_q[0]));
    a_hs = ans_m && !own_m && a_resp_ready;
    b_hs = ans_m && own_m && b_resp_ready;

    if (dmi_resp_valid && drr) dm_busy = 0;
    else if (dm_busy) dm_k++;

    if (a_hs || b_hs) begin
      if (a_hs) begin
        last_a = {a_resp_resp, a_resp_data}; n_resp_a++;
        if (exp_a_q.size() > 0) void'(exp_a_q.pop_front());
      end else begin
        last_b = {b_resp_resp, b_resp_data}; n_resp_b++;
        if (exp_b_q.size() > 0) void'(exp_b_q.pop_front());
      end
      last_m = own_m; open_m = 0; ans_m = 0;
    end

    // A response presented on the last counted cycle still wins over the timeout.
    if (wait_m) begin
      if (dmi_resp_valid || k_m == T - 1) begin
        ans_m = 1; wait_m = 0;
      end else k_m++;
    end

    if (fwd_m && dmi_req_ready) begin
      fwd_m = 0; wait_m = 1; k_m = 0; n_dmi++;
      void'(fwd_q.pop_front());
      dm_busy = 1; dm_k = 0;
      dm_d    = (dm_delay < 0) ? int'($urandom_range(T)) : dm_delay;
      dm_rsp  = dm_rand ? {($urandom_range(1) == 1) ? 2'd2 : 2'd0, 32'($urandom())} : dm_fix;
      if (own_m) exp_b_q.push_back((dm_d <= T - 1) ? dm_rsp : {2'd2, 32'd0});
      else       exp_a_q.push_back((dm_d <= T - 1) ? dm_rsp : {2'd2, 32'd0});
    end

    if (ga || gb) begin
      grant_log.push_back(gb);
      r = gb ? req_b_q.pop_front() : req_a_q.pop_front();
      open_m = 1; own_m = gb;
      if (r[40:39] == 2'd3) begin
        ans_m = 1;
        if (gb) exp_b_q.push_back({2'd2, 32'd0});
        else    exp_a_q.push_back({2'd2, 32'd0});
      end else begin
        fwd_m = 1;
        fwd_q.push_back(r);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    a_req_valid = 1; b_req_valid = 1; dmi_resp_valid = 1; dmi_req_ready = 1;
    a_resp_ready = 1; b_resp_ready = 1;
    a_req_op = 2'd1; b_req_op = 2'd2; a_req_addr = 7'h11; b_req_addr = 7'h22;
    a_req_data = 32'h1234; b_req_data = 32'h5678;
    dmi_resp_data = 32'hFFFF_FFFF; dmi_resp_resp = 2'd0;
    #12;
    check_all_zero("reset");
    @(negedge clock);
    model_clear();
    a_req_valid = 0; b_req_valid = 0; dmi_resp_valid = 0;
    reset_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int na, nd;
    n_resp_a = 0; n_resp_b = 0; n_dmi = 0; last_a = '0; last_b = '0;
    dm_delay = 0; dm_rand = 1; dm_fix = '0;
    a_rdy_pct = 100; b_rdy_pct = 100; dmi_rdy_pct = 100;
    model_clear();
    do_reset();

    // A read, response two cycles after the DMI request
    dm_rand = 0; dm_fix = {2'd0, 32'hDEADBEEF}; dm_delay = 1;
    req_a_q.push_back({2'd1, 32'h0, 7'h11});
    run(8);
    check("read_a_data", 64'(last_a), 64'({2'd0, 32'hDEADBEEF}));
    check("read_b_idle", 64'(n_resp_b), 64'd0);

    // simultaneous requesters alternate A, B, A, B, A
    do_reset();
    dm_rand = 1; dm_delay = 0;
    for (int i = 0; i < 3; i++) req_a_q.push_back(rand_req(2'd1));
    for (int i = 0; i < 2; i++) req_b_q.push_back(rand_req(2'd2));
    run(30);
    check("rr_count", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check($sformatf("rr_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));

    // B write times out; the late response is drained afterwards
    dm_delay = T;
    req_b_q.push_back(rand_req(2'd2));
    run(T + 10);
    check("timeout_b", 64'(last_b), 64'({2'd2, 32'd0}));

    // reserved op answered without touching the DMI
    dm_delay = 0; nd = n_dmi;
    req_a_q.push_back(rand_req(2'd3));
    run(4);
    check("op3_resp", 64'(last_a), 64'({2'd2, 32'd0}));
    check("op3_no_fwd", 64'(n_dmi - nd), 64'd0);

    // stalls on both sides; one response only
    na = n_resp_a;
    dmi_rdy_pct = 0;
    req_a_q.push_back(rand_req(2'd1));
    run(6);
    dmi_rdy_pct = 100; a_rdy_pct = 0;
    run(5);
    a_rdy_pct = 100;
    run(4);
    check("stall_one_resp", 64'(n_resp_a - na), 64'd1);

    // reset pulsed while waiting for the DM
    dm_delay = 100;
    req_b_q.push_back(rand_req(2'd1));
    run(3);
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset_wait");
    @(negedge clock);
    model_clear();
    reset_n = 1'b1;
    dm_delay = 0;
    req_b_q.push_back(rand_req(2'd1));
    req_a_q.push_back(rand_req(2'd1));
    run(12);
    check("post_reset_grant", 64'(grant_log.size() > 0 ? grant_log[0] : 1'b1), 64'd0);

    // randomized traffic
    dm_delay = -1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        a_rdy_pct   = $urandom_range(100, 40);
        b_rdy_pct   = $urandom_range(100, 40);
        dmi_rdy_pct = $urandom_range(100, 40);
      end
      if ($urandom_range(99) < 25 && req_a_q.size() < 2) req_a_q.push_back(rand_req(2'($urandom_range(3))));
      if ($urandom_range(99) < 25 && req_b_q.size() < 2) req_b_q.push_back(rand_req(2'($urandom_range(3))));
      cycle();
    end
    a_rdy_pct = 100; b_rdy_pct = 100; dmi_rdy_pct = 100;
    run(80);
    check("final_drain", 64'(req_a_q.size() + req_b_q.size() + exp_a_q.size() + exp_b_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
